mul_div_32: RTL and testbench
=============================

Name: mul_div_32

Overview:
- Multi-cycle signed multiply/divide stage for the MUL (4'b1000) and DIV (4'b1001) opcodes. The combinational ALU returns 0 for these opcodes.
- Consumes the same A/B operand pair and opcode encoding as the ALU.
- Produces a 64-bit result split into HI/LO. This result feeds the HI/LO (Z) registers downstream.
- Uses a start/busy/done handshake so the control unit can stall during the fixed-length iteration.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits. Only 32 is verified.

Ports:
- in_clk  input  1  single clock; all state updates on the rising edge.
- in_rst  input  1  reset; asynchronous, active-high.
- in_start  input  1  request a new operation; sampled only in IDLE.
- in_opcode  input  4  4'b1000 = MUL, 4'b1001 = DIV; any other value is ignored.
- in_a  input  32  multiplicand / dividend (signed two's complement).
- in_b  input  32  multiplier / divisor (signed two's complement).
- out_busy  output  1  high while an accepted operation is in progress.
- out_done  output  1  one-cycle pulse; out_hi/out_lo are valid from this cycle onward.
- out_hi  output  32  MUL: upper product word; DIV: remainder.
- out_lo  output  32  MUL: lower product word; DIV: quotient.
- out_div_by_zero  output  1  set with out_done when DIV had in_b = 0; cleared at the next acceptance.

Behaviour:
- Reset (async, any state, including mid-operation):
  - State goes to IDLE; iteration counter = 0.
  - out_busy = 0, out_done = 0, out_hi = 0, out_lo = 0, out_div_by_zero = 0.
  - Any in-flight operation is discarded.
- States: IDLE, RUN, FINISH, DONE.
- IDLE:
  - If in_start = 1 and in_opcode is MUL or DIV at edge T: latch in_a, in_b and the op into internal registers, clear out_div_by_zero, counter = 0, go to RUN.
  - Otherwise stay in IDLE. in_start with an invalid opcode is silently ignored.
- RUN:
  - One iteration per clock for exactly 32 clocks (counter 0..31); after the counter = 31 iteration, go to FINISH.
  - MUL: radix-2 Booth on the latched operands with a 64-bit product accumulator.
  - DIV: restoring division on operand magnitudes; the dividend and divisor signs are recorded at acceptance.
- FINISH (1 clock):
  - DIV: apply sign correction. Quotient is negated if the signs differ (truncation toward zero). Remainder takes the sign of the dividend.
  - Register out_hi/out_lo, then go to DONE.
- DONE (1 clock): out_done = 1, out_busy = 0; go to IDLE. in_start is not accepted in DONE.
- Timing:
  - out_busy = 1 in RUN and FINISH: 33 cycles, asserted the cycle after acceptance edge T.
  - Fixed latency: out_done rises after edge T+34, for both ops and all operand values.
- out_hi/out_lo hold their last values until the next FINISH. They do not change during RUN.
- Operand changes on in_a/in_b/in_opcode while busy have no effect.
- in_start while busy is ignored; it is neither queued nor an error.
- MUL arithmetic: full 64-bit signed product, {out_hi, out_lo} = in_a × in_b. Overflow is impossible.
- DIV by zero:
  - Iteration still runs for the full latency.
  - Result forced to out_lo = 32'hFFFFFFFF, out_hi = latched in_a.
  - out_div_by_zero = 1 from FINISH onward, held until the next acceptance.
- DIV overflow: 32'h80000000 / 32'hFFFFFFFF gives out_lo = 32'h80000000 (wraps), out_hi = 0, no flag.
- Remainder invariant: |remainder| < |divisor|, and quotient × divisor + remainder = dividend (mod 2^32).
- Back-to-back operation: the earliest next acceptance is the IDLE cycle after DONE, so the minimum initiation interval is 35 clocks.

Test Plan:
- MUL a = 7, b = 32'hFFFFFFFD (-3), start pulse -> busy for 33 cycles; done at T+34; out_hi = 32'hFFFFFFFF, out_lo = 32'hFFFFFFEB; flag 0.
- MUL a = b = 32'h7FFFFFFF -> out_hi = 32'h3FFFFFFF, out_lo = 32'h00000001. Then MUL 32'h80000000 × 32'h80000000 -> out_hi = 32'h40000000, out_lo = 0.
- DIV a = 32'hFFFFFFEF (-17), b = 5 -> out_lo = 32'hFFFFFFFD (-3), out_hi = 32'hFFFFFFFE (-2). Then DIV 17 / -5 -> out_lo = 32'hFFFFFFFD, out_hi = 2.
- DIV by zero with a = 32'h00001234, b = 0 -> done at T+34, out_lo = 32'hFFFFFFFF, out_hi = 32'h00001234, out_div_by_zero = 1.
- Next valid MUL 2 × 3 -> flag clears at acceptance; result out_hi = 0, out_lo = 6.
- DIV 32'h80000000 / 32'hFFFFFFFF -> out_lo = 32'h80000000, out_hi = 0, flag 0.
- Start MUL, then each of the following, checking the stated response:
  - Pulse in_start with new operands at cycle 10 -> ignored; original result delivered.
  - Start with opcode 4'b0110 in IDLE -> no busy.
  - Assert in_rst at cycle 20 of an operation -> busy/done/hi/lo all 0 immediately (async), no done pulse afterward.

Source files
------------

// File: rtl/mul_div_32.sv
// ---------------------------------------------------------------------------
// mul_div_32
//
// Multi-cycle signed multiply / divide stage for the MUL and DIV opcodes.
// A fixed-length iteration (radix-2 Booth for MUL, restoring division on
// magnitudes for DIV) produces a 2*WIDTH-bit result split into HI / LO.
// The latency is the same for every operand value, so the control unit
// only needs to stall on out_busy and wait for out_done.
//
// Ports:
//   in_clk           clock, all state updates on the rising edge
//   in_rst           asynchronous, active-high reset
//   in_start         request a new operation (sampled only in IDLE)
//   in_opcode        4'b1000 = MUL, 4'b1001 = DIV, anything else ignored
//   in_a             multiplicand / dividend (signed)
//   in_b             multiplier / divisor (signed)
//   out_busy         high while an accepted operation is in progress
//   out_done         one-cycle pulse; out_hi / out_lo valid from here on
//   out_hi           MUL: upper product word, DIV: remainder
//   out_lo           MUL: lower product word, DIV: quotient
//   out_div_by_zero  DIV with in_b = 0; held until the next acceptance
// ---------------------------------------------------------------------------
module mul_div_32 #(
    parameter int WIDTH = 32
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic             in_start,
    input  logic [3:0]       in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_busy,
    output logic             out_done,
    output logic [WIDTH-1:0] out_hi,
    output logic [WIDTH-1:0] out_lo,
    output logic             out_div_by_zero
);

    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam int         CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH,
        S_DONE
    } state_t;

    // Two's-complement magnitude; -2^(WIDTH-1) maps to 2^(WIDTH-1), which
    // still fits as an unsigned WIDTH-bit value.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q,    state_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic             is_div_q,   is_div_d;
    logic             sign_a_q,   sign_a_d;
    logic             sign_b_q,   sign_b_d;
    logic             b_zero_q,   b_zero_d;
    logic [WIDTH-1:0] a_q,        a_d;
    // MUL: multiplicand. DIV: divisor magnitude.
    logic [WIDTH-1:0] m_q,        m_d;
    // MUL: {acc_hi, acc_lo} is the Booth accumulator, acc_hi carries one
    //      guard bit so that subtracting -2^(WIDTH-1) cannot overflow.
    // DIV: acc_hi holds the partial remainder, acc_lo the dividend bits
    //      being shifted out and the quotient bits being shifted in.
    logic [WIDTH:0]   acc_hi_q,   acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q,   acc_lo_d;
    logic             booth_q,    booth_d;     // Booth q(-1) bit
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;
    logic [WIDTH-1:0] hi_q,       hi_d;
    logic [WIDTH-1:0] lo_q,       lo_d;
    logic             dbz_q,      dbz_d;

    // ------------------------------------------------------------------
    // Datapath for one iteration
    // ------------------------------------------------------------------
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   booth_hi;
    logic [WIDTH-1:0] booth_lo;

    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_trial;
    logic [WIDTH:0]   div_hi;
    logic [WIDTH-1:0] div_lo;

    logic [WIDTH-1:0] quo_fixed;
    logic [WIDTH-1:0] rem_fixed;

    always_comb begin
        m_ext = {m_q[WIDTH-1], m_q};

        // Booth recoding of {Q[0], q(-1)}: 01 adds, 10 subtracts.
        unique case ({acc_lo_q[0], booth_q})
            2'b01:   booth_sum = acc_hi_q + m_ext;
            2'b10:   booth_sum = acc_hi_q - m_ext;
            default: booth_sum = acc_hi_q;
        endcase
        // Arithmetic shift right of the whole accumulator.
        booth_hi = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        booth_lo = {booth_sum[0], acc_lo_q[WIDTH-1:1]};

        // Restoring step: bring in the next dividend bit, try to subtract.
        // The partial remainder is always below the divisor, so bit WIDTH
        // of either candidate is zero and the restored value fits.
        div_shift = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, m_q};
        if (div_trial[WIDTH+1]) begin
            div_hi = div_shift;
            div_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
        end else begin
            div_hi = div_trial[WIDTH:0];
            div_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
        end

        // Truncation toward zero: quotient negative when signs differ,
        // remainder follows the dividend.
        quo_fixed = (sign_a_q ^ sign_b_q) ? -acc_lo_q : acc_lo_q;
        rem_fixed = sign_a_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        b_zero_d = b_zero_q;
        a_d      = a_q;
        m_d      = m_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        booth_d  = booth_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;

        // Handshake outputs are registered from the current state, so they
        // trail the state register by one clock.
        busy_d   = (state_q == S_RUN) || (state_q == S_FINISH);
        done_d   = (state_q == S_DONE);

        unique case (state_q)
            S_IDLE: begin
                if (in_start && ((in_opcode == OP_MUL) || (in_opcode == OP_DIV))) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    is_div_d = (in_opcode == OP_DIV);
                    sign_a_d = in_a[WIDTH-1];
                    sign_b_d = in_b[WIDTH-1];
                    b_zero_d = (in_b == '0);
                    a_d      = in_a;
                    acc_hi_d = '0;
                    booth_d  = 1'b0;
                    dbz_d    = 1'b0;
                    if (in_opcode == OP_DIV) begin
                        m_d      = mag(in_b);
                        acc_lo_d = mag(in_a);
                    end else begin
                        m_d      = in_a;
                        acc_lo_d = in_b;
                    end
                end
            end

            S_RUN: begin
                if (is_div_q) begin
                    acc_hi_d = div_hi;
                    acc_lo_d = div_lo;
                end else begin
                    acc_hi_d = booth_hi;
                    acc_lo_d = booth_lo;
                    booth_d  = acc_lo_q[0];
                end
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    state_d = S_FINISH;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end

            S_FINISH: begin
                if (!is_div_q) begin
                    hi_d = acc_hi_q[WIDTH-1:0];
                    lo_d = acc_lo_q;
                end else if (b_zero_q) begin
                    hi_d  = a_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else begin
                    hi_d = rem_fixed;
                    lo_d = quo_fixed;
                end
                state_d = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    // NOTE: all state is reset, including the datapath registers, so an
    // operation interrupted by reset leaves nothing behind.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
            a_q      <= '0;
            m_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            booth_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            b_zero_q <= b_zero_d;
            a_q      <= a_d;
            m_q      <= m_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            booth_q  <= booth_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dbz_q    <= dbz_d;
        end
    end

    assign out_busy        = busy_q;
    assign out_done        = done_q;
    assign out_hi          = hi_q;
    assign out_lo          = lo_q;
    assign out_div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_32.sv
// ---------------------------------------------------------------------------
// tb_mul_div_32
//
// Scoreboard bench for mul_div_32: each accepted operation pushes its
// expected result and acceptance cycle; a monitor pops on out_done and
// checks result, flag, latency and busy length.
// ---------------------------------------------------------------------------
module tb_mul_div_32;

    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;

    logic        in_clk;
    logic        in_rst;
    logic        in_start;
    logic [3:0]  in_opcode;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_busy;
    logic        out_done;
    logic [31:0] out_hi;
    logic [31:0] out_lo;
    logic        out_div_by_zero;

    mul_div_32 #(.WIDTH(32)) dut (
        .in_clk          (in_clk),
        .in_rst          (in_rst),
        .in_start        (in_start),
        .in_opcode       (in_opcode),
        .in_a            (in_a),
        .in_b            (in_b),
        .out_busy        (out_busy),
        .out_done        (out_done),
        .out_hi          (out_hi),
        .out_lo          (out_lo),
        .out_div_by_zero (out_div_by_zero)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    typedef struct {
        int          id;
        int          t_acc;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t q_exp[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    int   op_id    = 0;

    always @(posedge in_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent arithmetic model on 64-bit signed integers.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint r64;
        longint q64;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.id = 0;
        e.t_acc = 0;
        e.dbz = 1'b0;
        if (op == OP_MUL) begin
            r64  = sa * sb;
            e.hi = r64[63:32];
            e.lo = r64[31:0];
        end else if (b == 32'h0) begin
            e.hi  = a;
            e.lo  = 32'hFFFFFFFF;
            e.dbz = 1'b1;
        end else begin
            q64  = sa / sb;
            r64  = sa % sb;
            e.hi = r64[31:0];
            e.lo = q64[31:0];
        end
        return e;
    endfunction

    // Drive a start pulse so it is sampled at the next rising edge (edge T).
    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input exp_t e, input bit accept);
        exp_t ee;
        @(negedge in_clk);
        in_start  = 1'b1;
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        @(posedge in_clk);
        #1;
        in_start  = 1'b0;
        in_a      = $urandom;
        in_b      = $urandom;
        if (accept) begin
            ee       = e;
            ee.id    = op_id;
            ee.t_acc = cyc;
            op_id++;
            q_exp.push_back(ee);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q_exp.size() != 0 && n < 60) begin
            @(posedge in_clk);
            n++;
        end
        #2;
        check("timeout_pending", 64'(q_exp.size()), 64'd0);
        q_exp.delete();
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge in_clk);
            #1;
            if (!in_rst) begin
                if (out_busy) busy_cnt++;
                if (out_done) begin
                    if (q_exp.size() == 0) begin
                        check("spurious_done", 64'(out_done), 64'd0);
                    end else begin
                        e = q_exp.pop_front();
                        check($sformatf("op%0d_hi", e.id), 64'(out_hi), 64'(e.hi));
                        check($sformatf("op%0d_lo", e.id), 64'(out_lo), 64'(e.lo));
                        check($sformatf("op%0d_dbz", e.id), 64'(out_div_by_zero), 64'(e.dbz));
                        check($sformatf("op%0d_latency", e.id), 64'(cyc - e.t_acc), 64'd34);
                        check($sformatf("op%0d_busy_len", e.id), 64'(busy_cnt), 64'd33);
                        check($sformatf("op%0d_busy_at_done", e.id), 64'(out_busy), 64'd0);
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rop;

        in_rst    = 1'b1;
        in_start  = 1'b0;
        in_opcode = 4'h0;
        in_a      = 32'h0;
        in_b      = 32'h0;
        #12;
        check("rst_busy", 64'(out_busy), 64'd0);
        check("rst_done", 64'(out_done), 64'd0);
        check("rst_hi",   64'(out_hi),   64'd0);
        check("rst_lo",   64'(out_lo),   64'd0);
        check("rst_dbz",  64'(out_div_by_zero), 64'd0);
        @(negedge in_clk);
        in_rst = 1'b0;
        repeat (2) @(negedge in_clk);

        // Directed vectors with constant expectations.
        start_op(OP_MUL, 32'd7, 32'hFFFFFFFD, '{0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0}, 1'b1);
        check("busy_edge_t", 64'(out_busy), 64'd0);
        @(posedge in_clk); #1;
        check("busy_edge_t1", 64'(out_busy), 64'd1);
        wait_idle();
        start_op(OP_MUL, 32'h7FFFFFFF, 32'h7FFFFFFF, '{0, 0, 32'h3FFFFFFF, 32'h00000001, 1'b0}, 1'b1);
        wait_idle();
        start_op(OP_MUL, 32'h80000000, 32'h80000000, '{0, 0, 32'h40000000, 32'h00000000, 1'b0}, 1'b1);
        wait_idle();
        start_op(OP_DIV, 32'hFFFFFFEF, 32'd5, '{0, 0, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0}, 1'b1);
        wait_idle();
        start_op(OP_DIV, 32'd17, 32'hFFFFFFFB, '{0, 0, 32'h00000002, 32'hFFFFFFFD, 1'b0}, 1'b1);
        wait_idle();
        start_op(OP_DIV, 32'h00001234, 32'h0, '{0, 0, 32'h00001234, 32'hFFFFFFFF, 1'b1}, 1'b1);
        wait_idle();
        check("dbz_held", 64'(out_div_by_zero), 64'd1);

        // Flag clears at acceptance; results hold during RUN.
        start_op(OP_MUL, 32'd2, 32'd3, '{0, 0, 32'h0, 32'h6, 1'b0}, 1'b1);
        check("dbz_cleared", 64'(out_div_by_zero), 64'd0);
        repeat (5) @(posedge in_clk);
        #1;
        check("hold_hi", 64'(out_hi), 64'h00001234);
        check("hold_lo", 64'(out_lo), 64'hFFFFFFFF);
        wait_idle();

        start_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, '{0, 0, 32'h0, 32'h80000000, 1'b0}, 1'b1);
        wait_idle();

        // Start pulse while busy is ignored.
        start_op(OP_MUL, 32'h00012345, 32'h00000777, model(OP_MUL, 32'h00012345, 32'h00000777), 1'b1);
        repeat (8) @(negedge in_clk);
        in_start  = 1'b1;
        in_opcode = OP_DIV;
        in_a      = 32'd100;
        in_b      = 32'd7;
        @(negedge in_clk);
        in_start  = 1'b0;
        wait_idle();

        // Invalid opcode in IDLE: nothing starts.
        start_op(4'b0110, 32'd9, 32'd9, '{0, 0, 32'h0, 32'h0, 1'b0}, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge in_clk);
            #1;
            check($sformatf("badop_busy%0d", i), 64'(out_busy), 64'd0);
        end

        // Randomised operations against the arithmetic model.
        for (int i = 0; i < 8; i++) begin
            ra  = $urandom;
            rb  = (i == 5) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom);
            rop = (i % 2 == 0) ? OP_DIV : OP_MUL;
            start_op(rop, ra, rb, model(rop, ra, rb), 1'b1);
            wait_idle();
        end

        // Reset in the middle of an operation.
        start_op(OP_MUL, 32'h11111111, 32'h22222222, model(OP_MUL, 32'h11111111, 32'h22222222), 1'b1);
        repeat (20) @(posedge in_clk);
        #3;
        in_rst = 1'b1;
        #1;
        check("midrst_busy", 64'(out_busy), 64'd0);
        check("midrst_done", 64'(out_done), 64'd0);
        check("midrst_hi",   64'(out_hi),   64'd0);
        check("midrst_lo",   64'(out_lo),   64'd0);
        q_exp.delete();
        busy_cnt = 0;
        @(negedge in_clk);
        in_rst = 1'b0;
        repeat (40) @(posedge in_clk);
        #1;
        check("postrst_busy", 64'(out_busy), 64'd0);
        check("postrst_lo",   64'(out_lo),   64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
